// File: rtl/i2c_reg_arbiter.sv
`default_nettype none
// =============================================================================
// Module      : i2c_reg_arbiter
// Description : Shares one register-memory port between posted I2C writes
//               (buffered in a small FIFO) and a request/grant host port.
//               Optional write protection of the upper address range against
//               I2C is compiled in with macro I2C_ARB_WP_EN.
// Revision    : 1.0 - initial release
// =============================================================================
module i2c_reg_arbiter #(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] WP_BASE    = 8'hF0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] i2c_addr,
    input  logic [7:0] i2c_data,
    input  logic       i2c_wr,
    input  logic       host_req,
    input  logic       host_we,
    input  logic [7:0] host_addr,
    input  logic [7:0] host_wdata,
    output logic       host_gnt,
    output logic [7:0] host_rdata,
    output logic       host_rvalid,
    output logic       mem_en,
    output logic       mem_we,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata,
    output logic       ovf,
    input  logic       ovf_clr,
    output logic       wp_err
);
    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PRI_LVL = (AW+1)'(FIFO_DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        I2C_WR  = 3'd1,
        HOST_WR = 3'd2,
        HOST_RD = 3'd3,
        RD_WAIT = 3'd4
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] fifo_mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr, fifo_cnt;
    logic [15:0] head;
    logic        fifo_empty, fifo_full, fifo_pri;
    logic        pop, push, push_req, drop, wp_hit;
    logic        last_fifo, grant_fifo, grant_host;
    logic        en_nxt, we_nxt, gnt_nxt;
    logic [7:0]  addr_nxt, wdata_nxt;

`ifdef I2C_ARB_WP_EN
    assign wp_hit = i2c_wr && (i2c_addr >= WP_BASE);

    always_ff @(posedge clk) begin
        if (rst) wp_err <= 1'b0;
        else     wp_err <= wp_hit;
    end
`else
    logic wp_base_unused;
    assign wp_base_unused = ^WP_BASE;
    assign wp_hit         = 1'b0;
    assign wp_err         = 1'b0;
`endif

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign fifo_cnt   = wr_ptr - rd_ptr;
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign fifo_pri   = (fifo_cnt >= PRI_LVL);
    assign head       = fifo_mem[rd_ptr[AW-1:0]];
    assign pop        = (state == I2C_WR);
    assign push_req   = i2c_wr && !wp_hit;
    assign push       = push_req && (!fifo_full || pop);
    assign drop       = push_req && fifo_full && !pop;

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr[AW-1:0]] <= {i2c_addr, i2c_data};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (drop)         ovf <= 1'b1;
            else if (ovf_clr) ovf <= 1'b0;
        end
    end

    always_comb begin
        state_nxt  = state;
        grant_fifo = 1'b0;
        grant_host = 1'b0;
        en_nxt     = 1'b0;
        we_nxt     = mem_we;
        gnt_nxt    = 1'b0;
        addr_nxt   = mem_addr;
        wdata_nxt  = mem_wdata;
        case (state)
            IDLE: begin
                // FIFO wins when nearly full, otherwise the side not served last wins a tie.
                if (!fifo_empty && (!host_req || fifo_pri || !last_fifo)) begin
                    grant_fifo = 1'b1;
                    state_nxt  = I2C_WR;
                    en_nxt     = 1'b1;
                    we_nxt     = 1'b1;
                    addr_nxt   = head[15:8];
                    wdata_nxt  = head[7:0];
                end else if (host_req) begin
                    grant_host = 1'b1;
                    state_nxt  = host_we ? HOST_WR : HOST_RD;
                    en_nxt     = 1'b1;
                    we_nxt     = host_we;
                    gnt_nxt    = 1'b1;
                    addr_nxt   = host_addr;
                    if (host_we) wdata_nxt = host_wdata;
                end
            end
            I2C_WR:  state_nxt = IDLE;
            HOST_WR: state_nxt = IDLE;
            HOST_RD: state_nxt = RD_WAIT;
            RD_WAIT: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            last_fifo <= 1'b1;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 8'h00;
            mem_wdata <= 8'h00;
            host_gnt  <= 1'b0;
        end else begin
            state     <= state_nxt;
            mem_en    <= en_nxt;
            mem_we    <= we_nxt;
            mem_addr  <= addr_nxt;
            mem_wdata <= wdata_nxt;
            host_gnt  <= gnt_nxt;
            if (grant_fifo)      last_fifo <= 1'b1;
            else if (grant_host) last_fifo <= 1'b0;
        end
    end

    // Read data arrives one cycle after the strobe, so it is forwarded straight through.
    assign host_rvalid = (state == RD_WAIT) && !rst;
    assign host_rdata  = host_rvalid ? mem_rdata : 8'h00;

endmodule
`default_nettype wire
